// File: rtl/dig_clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dig_clock_pkg
//  Description : Shared constants, types and the segment encoder for the
//                digital-clock display slice.
//  Revision    : 1.0
// ============================================================================
package dig_clock_pkg;

    localparam int c_num_digits = 4;
    localparam int c_hour_w     = 5;
    localparam int c_field_w    = 6;
    localparam int c_bcd_w      = 4;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] c_seg_0     = 7'b1000000;
    localparam logic [6:0] c_seg_1     = 7'b1111001;
    localparam logic [6:0] c_seg_2     = 7'b0100100;
    localparam logic [6:0] c_seg_3     = 7'b0110000;
    localparam logic [6:0] c_seg_4     = 7'b0011001;
    localparam logic [6:0] c_seg_5     = 7'b0010010;
    localparam logic [6:0] c_seg_6     = 7'b0000010;
    localparam logic [6:0] c_seg_7     = 7'b1111000;
    localparam logic [6:0] c_seg_8     = 7'b0000000;
    localparam logic [6:0] c_seg_9     = 7'b0010000;
    localparam logic [6:0] c_seg_dash  = 7'b0111111;
    localparam logic [6:0] c_seg_blank = 7'b1111111;

    localparam logic [5:0] c_max_hours = 6'd23;
    localparam logic [5:0] c_max_min   = 6'd59;

    typedef enum logic [1:0] {
        DIG_R_UNITS = 2'd0,
        DIG_R_TENS  = 2'd1,
        DIG_L_UNITS = 2'd2,
        DIG_L_TENS  = 2'd3
    } digit_idx_t;

    function automatic logic [6:0] seg_encode(input logic [c_bcd_w-1:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = c_seg_0;
            4'd1:    code = c_seg_1;
            4'd2:    code = c_seg_2;
            4'd3:    code = c_seg_3;
            4'd4:    code = c_seg_4;
            4'd5:    code = c_seg_5;
            4'd6:    code = c_seg_6;
            4'd7:    code = c_seg_7;
            4'd8:    code = c_seg_8;
            4'd9:    code = c_seg_9;
            default: code = c_seg_blank;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd
//  Description : Combinational 6-bit binary to two-digit BCD (tens, units).
//  Revision    : 1.0
// ============================================================================
module bin_to_bcd
    import dig_clock_pkg::*;
(
    input  logic [c_field_w-1:0] i_bin,
    output logic [c_bcd_w-1:0]   o_tens,
    output logic [c_bcd_w-1:0]   o_units
);

    logic [c_field_w-1:0] w_base;

    always_comb begin
        if (i_bin >= 6'd60) begin
            o_tens = 4'd6; w_base = 6'd60;
        end else if (i_bin >= 6'd50) begin
            o_tens = 4'd5; w_base = 6'd50;
        end else if (i_bin >= 6'd40) begin
            o_tens = 4'd4; w_base = 6'd40;
        end else if (i_bin >= 6'd30) begin
            o_tens = 4'd3; w_base = 6'd30;
        end else if (i_bin >= 6'd20) begin
            o_tens = 4'd2; w_base = 6'd20;
        end else if (i_bin >= 6'd10) begin
            o_tens = 4'd1; w_base = 6'd10;
        end else begin
            o_tens = 4'd0; w_base = 6'd0;
        end
        o_units = 4'(i_bin - w_base);
    end

endmodule
`default_nettype wire

// File: rtl/time_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : time_display_scan
//  Description : Multiplexed 4-digit 7-segment scanner for HH:MM / MM:SS.
//                Optional macro LEADING_ZERO_BLANK_EN blanks a leading zero.
//  Revision    : 1.0
// ============================================================================
module time_display_scan
    import dig_clock_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [c_hour_w-1:0]     hours,
    input  logic [c_field_w-1:0]    minutes,
    input  logic [c_field_w-1:0]    seconds,
    input  logic                    time_valid,
    input  logic                    mode,
    output logic [c_num_digits-1:0] an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int                   c_presc_w   = $clog2(REFRESH_DIV);
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(REFRESH_DIV - 1);

    logic [c_hour_w-1:0]  r_h;
    logic [c_field_w-1:0] r_m;
    logic [c_field_w-1:0] r_s;
    logic [c_presc_w-1:0] r_presc;
    digit_idx_t           r_idx;

    logic [c_field_w-1:0] w_left_bin;
    logic [c_field_w-1:0] w_right_bin;
    logic                 w_left_ok;
    logic                 w_right_ok;
    logic [c_bcd_w-1:0]   w_left_tens;
    logic [c_bcd_w-1:0]   w_left_units;
    logic [c_bcd_w-1:0]   w_right_tens;
    logic [c_bcd_w-1:0]   w_right_units;
    logic [6:0]           w_seg_next;

    // Mode is taken live so a toggle reaches the display on the next edge.
    always_comb begin
        w_left_bin  = mode ? r_m : {1'b0, r_h};
        w_right_bin = mode ? r_s : r_m;
        w_left_ok   = mode ? (r_m <= c_max_min) : ({1'b0, r_h} <= c_max_hours);
        w_right_ok  = mode ? (r_s <= c_max_min) : (r_m <= c_max_min);
    end

    bin_to_bcd u_left_bcd (
        .i_bin   (w_left_bin),
        .o_tens  (w_left_tens),
        .o_units (w_left_units)
    );

    bin_to_bcd u_right_bcd (
        .i_bin   (w_right_bin),
        .o_tens  (w_right_tens),
        .o_units (w_right_units)
    );

    always_comb begin
        w_seg_next = c_seg_blank;
        case (r_idx)
            DIG_R_UNITS: w_seg_next = w_right_ok ? seg_encode(w_right_units) : c_seg_dash;
            DIG_R_TENS:  w_seg_next = w_right_ok ? seg_encode(w_right_tens)  : c_seg_dash;
            DIG_L_UNITS: w_seg_next = w_left_ok  ? seg_encode(w_left_units)  : c_seg_dash;
            DIG_L_TENS: begin
                if (!w_left_ok) begin
                    w_seg_next = c_seg_dash;
                end else begin
`ifdef LEADING_ZERO_BLANK_EN
                    w_seg_next = (w_left_tens == 4'd0) ? c_seg_blank : seg_encode(w_left_tens);
`else
                    w_seg_next = seg_encode(w_left_tens);
`endif
                end
            end
            default: w_seg_next = c_seg_blank;
        endcase
    end

    // Outputs use the pre-edge snapshot and index, giving one cycle of latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_h     <= '0;
            r_m     <= '0;
            r_s     <= '0;
            r_presc <= '0;
            r_idx   <= DIG_R_UNITS;
            an      <= '1;
            seg     <= c_seg_blank;
            dp      <= 1'b1;
        end else begin
            if (time_valid) begin
                r_h <= hours;
                r_m <= minutes;
                r_s <= seconds;
            end
            if (r_presc == c_presc_max) begin
                r_presc <= '0;
                r_idx   <= digit_idx_t'(r_idx + 2'd1);
            end else begin
                r_presc <= r_presc + c_presc_w'(1);
            end
            an  <= ~(4'b0001 << r_idx);
            seg <= w_seg_next;
            dp  <= ~((r_idx == DIG_L_UNITS) && !r_s[0]);
        end
    end

endmodule
`default_nettype wire
